// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared definitions for the colour-detection SNN output stage:
//               decoder state encoding, default counter width, neuron
//               pipeline latency and the class index assignments.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

  // Default per-class spike counter width.
  localparam int CNT_W_DEF = 16;

  // Neuron latency from neuron_reset to a clean spike_out:
  // 4-stage adder tree plus the membrane voltage register.
  localparam int NEURON_PIPE_LAT = 5;

  // Class index assignments of the output-layer neurons.
  localparam logic [1:0] CLS_RED   = 2'd0;
  localparam logic [1:0] CLS_GREEN = 2'd1;
  localparam logic [1:0] CLS_BLUE  = 2'd2;
  localparam logic [1:0] CLS_NONE  = 2'd3;

  // Decoder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NRST   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_COUNT  = 3'd3,
    ST_DECIDE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage : snn_pkg
`default_nettype wire

// File: rtl/spike_counter_sat.sv
`default_nettype none
// ============================================================================
// Module      : spike_counter_sat
// Description : Single unsigned saturating spike counter.
//   clk   in  system clock (rising edge)
//   reset in  synchronous active-high reset, clears count
//   clr   in  synchronous clear (priority over counting)
//   en    in  counting enable
//   inc   in  spike to count when enabled
//   count out current count, sticks at 2^CNT_W-1
// Revision    : 1.0 - initial release
// ============================================================================
module spike_counter_sat
  import snn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && inc && (count != C_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule : spike_counter_sat
`default_nettype wire

// File: rtl/spike_class_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_class_decoder
// Description : Classifies a frame from the output-layer spike trains. Clears
//               the class neurons, waits out their pipeline, counts spikes per
//               class over a fixed window, then runs a sequential argmax.
//   clk          in  system clock (rising edge)
//   reset        in  synchronous active-high reset
//   start        in  request a classification (sampled in IDLE only)
//   spike_in     in  spike_out of each class neuron, bit i = class i
//   neuron_reset out one-cycle clear pulse for all class neurons
//   busy         out high whenever not IDLE
//   class_valid  out one-cycle result strobe
//   class_out    out winning class index (held until next result)
//   win_count    out spike count of the winner (held)
//   no_spike     out every class count was zero (held)
// Revision    : 1.0 - initial release
// ============================================================================
module spike_class_decoder
  import snn_pkg::*;
#(
  parameter int N_CLASSES = 4,
  parameter int CLASS_W   = 2,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SETTLE    = NEURON_PIPE_LAT,
  parameter int WINDOW    = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_CLASSES-1:0] spike_in,
  output logic                 neuron_reset,
  output logic                 busy,
  output logic                 class_valid,
  output logic [CLASS_W-1:0]   class_out,
  output logic [CNT_W-1:0]     win_count,
  output logic                 no_spike
);

  // One timer serves both SETTLE and COUNT phases, so it is sized for the larger.
  localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Timers count down to zero, so load length-1.
  localparam logic [TMR_W-1:0]   C_SETTLE_LD = (SETTLE > 0) ? TMR_W'(SETTLE - 1) : '0;
  localparam logic [TMR_W-1:0]   C_WINDOW_LD = TMR_W'(WINDOW - 1);
  localparam logic [CLASS_W-1:0] C_LAST_IDX  = CLASS_W'(N_CLASSES - 1);

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [CLASS_W-1:0] r_idx;
  logic [CLASS_W-1:0] r_best_idx;
  logic [CNT_W-1:0]   r_best_cnt;

  logic [CNT_W-1:0]   w_cnt [N_CLASSES];
  logic               w_take;
  logic [CLASS_W-1:0] w_next_idx;
  logic [CNT_W-1:0]   w_next_cnt;

  generate
    for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_cnt
      spike_counter_sat #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (r_state == ST_NRST),
        .en    (r_state == ST_COUNT),
        .inc   (spike_in[gi]),
        .count (w_cnt[gi])
      );
    end
  endgenerate

  // Strict greater-than keeps the earlier (lower) index on a tie.
  always_comb begin
    w_take     = (w_cnt[r_idx] > r_best_cnt);
    w_next_idx = w_take ? r_idx : r_best_idx;
    w_next_cnt = w_take ? w_cnt[r_idx] : r_best_cnt;
  end

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_idx        <= '0;
      r_best_idx   <= '0;
      r_best_cnt   <= '0;
      neuron_reset <= 1'b0;
      class_valid  <= 1'b0;
      class_out    <= '0;
      win_count    <= '0;
      no_spike     <= 1'b0;
    end else begin
      neuron_reset <= 1'b0;
      class_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_NRST;
            neuron_reset <= 1'b1;
          end
        end
        ST_NRST: begin
          if (SETTLE == 0) begin
            r_state <= ST_COUNT;
            r_timer <= C_WINDOW_LD;
          end else begin
            r_state <= ST_SETTLE;
            r_timer <= C_SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (r_timer == '0) begin
            r_state <= ST_COUNT;
            r_timer <= C_WINDOW_LD;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_COUNT: begin
          if (r_timer == '0) begin
            r_state    <= ST_DECIDE;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_DECIDE: begin
          r_best_idx <= w_next_idx;
          r_best_cnt <= w_next_cnt;
          if (r_idx == C_LAST_IDX) begin
            // Publish the result together with the strobe on entry to DONE.
            r_state     <= ST_DONE;
            class_valid <= 1'b1;
            class_out   <= w_next_idx;
            win_count   <= w_next_cnt;
            no_spike    <= (w_next_cnt == '0);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : spike_class_decoder
`default_nettype wire

// File: doc/spike_class_decoder.md
Name: spike_class_decoder

Overview:
- Output stage of the colour-detection SNN. Sits directly downstream of the output-layer neuron instances: takes one spike_out bit per class neuron and classifies the frame.
- For each classification it clears the neurons, waits for their adder pipeline to flush, counts spikes per class over a fixed window, and picks the class with the most spikes.
- Reports a one-cycle-valid class index to the colour-detection control logic.

Parameters:
- N_CLASSES, 4, number of output neurons/classes (e.g. red, green, blue, none); must be >= 2.
- CLASS_W, 2, width of the class index; must equal clog2(N_CLASSES).
- CNT_W, 16, per-class spike counter width; counters saturate.
- SETTLE, 5, cycles to ignore spikes after neuron_reset. Covers the neuron's 4-stage adder tree plus the voltage register.
- WINDOW, 256, number of counting cycles; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a classification; sampled only in IDLE.
- spike_in  in  N_CLASSES  spike_out of each class neuron, bit i = class i.
- neuron_reset  out  1  drives the neuron_reset input of every class neuron.
- busy  out  1  high in every state except IDLE.
- class_valid  out  1  one-cycle pulse when the result is ready.
- class_out  out  CLASS_W  winning class index.
- win_count  out  CNT_W  spike count of the winning class.
- no_spike  out  1  high when every class count is 0.

Behaviour:
- Reset value of every output is 0. Reset also sets state to IDLE and clears all counters, timers and result registers.
- Reset wins over any in-flight operation at the next edge. No result is produced for an aborted run.
- FSM states: IDLE, NRST, SETTLE, COUNT, DECIDE, DONE.
- IDLE: busy=0. If start=1, go to NRST.
- NRST: lasts 1 cycle. neuron_reset=1 (registered, high only in this cycle). All per-class counters clear to 0. Next state is SETTLE.
- SETTLE: lasts exactly SETTLE cycles, counted by a down-counter. spike_in is ignored. Next state is COUNT.
  - If SETTLE=0, NRST goes directly to COUNT.
- COUNT: lasts exactly WINDOW cycles. Each cycle, cnt[i] increments when spike_in[i]=1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - Next state is DECIDE.
- DECIDE: lasts exactly N_CLASSES cycles. Sequential argmax with one class compared per cycle, in index order from 0.
  - Comparison is strict greater-than, so a tie resolves to the lowest index.
  - Next state is DONE.
- DONE: lasts 1 cycle. class_valid=1. class_out, win_count and no_spike take their final values. Next state is IDLE.
- All-zero counts: class_out=0, win_count=0, no_spike=1, and class_valid still pulses.
- class_out, win_count and no_spike hold their values until the next DONE or reset. They are not cleared on start.
- start while busy=1 is ignored. It is not queued.
- start held high across DONE starts a new run. IDLE samples it in the cycle after DONE.
- Latency: take the edge that samples start in IDLE as edge 0.
  - neuron_reset is high after edge 0 and low after edge 1.
  - COUNT occupies the cycles after edges 1+SETTLE through SETTLE+WINDOW.
  - class_valid is high after edge 1+SETTLE+WINDOW+N_CLASSES for exactly one cycle.
- Width rules:
  - Counters are unsigned CNT_W.
  - The SETTLE/WINDOW timer is clog2(max(SETTLE,WINDOW)+1) bits.
  - The DECIDE index is CLASS_W bits and must not wrap past N_CLASSES-1 when N_CLASSES is not a power of 2.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum (IDLE..DONE);
  - the default CNT_W;
  - the NEURON_PIPE_LAT=5 constant, used as the SETTLE default;
  - the class index constants (CLS_RED=0, CLS_GREEN=1, CLS_BLUE=2, CLS_NONE=3).
- One sub-module, spike_counter_sat: a single saturating counter with clr, en, inc and a CNT_W output. It is instantiated N_CLASSES times in a generate loop.
- The FSM, timer and sequential argmax stay in the top module.

Test Plan:
- Base configuration for all scenarios unless stated: SETTLE=5, WINDOW=16, N_CLASSES=4, CNT_W=4.
- Pulse start with spike_in[1] tied high -> neuron_reset high for exactly 1 cycle after edge 0. class_valid after edge 26 with class_out=1, win_count=15 (saturated from 16), no_spike=0. busy low after edge 27.
- spike_in = 4'b1111 during SETTLE only, then 4'b0100 on 3 COUNT cycles -> class_out=2, win_count=3. Confirms SETTLE spikes are ignored.
- Classes 1 and 3 each spike on 7 COUNT cycles, all other cycles zero -> tie resolves to class_out=1, win_count=7.
- spike_in=0 throughout -> class_valid pulses with class_out=0, win_count=0, no_spike=1.
- Raise start again at edge 10, then assert reset at edge 12 mid-COUNT -> start at edge 10 has no effect. After reset, all outputs are 0 and busy=0. No class_valid pulse occurs, and a fresh start afterwards completes normally.
- start held high continuously -> back-to-back runs. neuron_reset pulses after edges 0, 28 and 56. class_valid pulses after edges 26 and 54.
